// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle controller and its datapath.
//   state_t      : controller state encoding (also what state_o reports)
//   OP_* / FN_*  : instruction opcode (instr[31:26]) and funct (instr[5:0]) values
//   ALU_*        : alu_func encoding, shared with the ALU so both sides agree
//   SRCB_*       : alu_src_b operand select encoding
//   PC_*         : pc_src next-PC select encoding
//   decode_funct : maps an R-type funct to {supported, alu_func}
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_R   = 4'd6,
        S_WB_I   = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALU_SLT = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Bit 2 flags a supported funct; bits 1:0 carry the ALU operation.
    function automatic logic [2:0] decode_funct(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return {1'b1, ALU_ADD};
            FN_SUB:  return {1'b1, ALU_SUB};
            FN_OR:   return {1'b1, ALU_OR};
            FN_SLT:  return {1'b1, ALU_SLT};
            default: return {1'b0, ALU_SLT};
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore-style control FSM for a multi-cycle MIPS subset
// (R-type add/sub/or/slt, lw, sw, addi, beq, j).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode, funct, zf     instruction fields and ALU zero flag
//   mem_req, mem_we       memory request / write qualifier
//   mem_ready             memory completes the request this cycle
//   alu_func, alu_src_a, alu_src_b   ALU operation and operand selects
//   pc_we, ir_we, reg_we  write strobes
//   iord, reg_dst, mem_to_reg, pc_src  datapath muxes
//   illegal               one-cycle pulse on an unsupported instruction
//   state_o               current state (debug)
// Memory handshake: in FETCH, MEM_RD and MEM_WR the request (mem_req plus
// iord/mem_we) is held stable until a cycle with mem_ready=1; that cycle
// completes the transfer. mem_ready is ignored in every other state.
module multi_cycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zf,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ready,
    output logic [1:0] alu_func,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     next_state;
    logic [2:0] fn_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    assign state_o = state;

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        alu_func   = ALU_SLT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = PC_ALU;
        illegal    = 1'b0;
        fn_dec     = decode_funct(funct);

        case (state)
            S_FETCH: begin
                // Reset parks the FSM here; rst_n gates the request and the
                // strobes so nothing is issued until reset is released.
                mem_req   = rst_n;
                alu_src_b = SRCB_FOUR;
                alu_func  = ALU_ADD;
                if (mem_ready) begin
                    ir_we      = rst_n;
                    pc_we      = rst_n;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                alu_func  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:             next_state = S_EXEC_R;
                    OP_LW, OP_SW, OP_ADDI: next_state = S_ADDR;
                    OP_BEQ:               next_state = S_BRANCH;
                    OP_J:                 next_state = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                if (fn_dec[2]) begin
                    alu_func   = fn_dec[1:0];
                    next_state = S_WB_R;
                end else begin
                    illegal    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_func  = ALU_ADD;
                case (opcode)
                    OP_LW:   next_state = S_MEM_RD;
                    OP_SW:   next_state = S_MEM_WR;
                    OP_ADDI: next_state = S_WB_I;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) next_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_WB_R: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                next_state = S_FETCH;
            end
            S_WB_I: begin
                reg_we     = 1'b1;
                next_state = S_FETCH;
            end
            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REGB;
                alu_func   = ALU_SUB;
                pc_we      = zf;
                pc_src     = PC_ALUOUT;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_we      = 1'b1;
                pc_src     = PC_JUMP;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed-vector bench for multi_cycle_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_cycle_ctrl;
    import ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zf;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ready;
    logic [1:0] alu_func;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zf         (zf),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .alu_func   (alu_func),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .iord       (iord),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    // ---------------- scoreboard ----------------
    int         n_cmp;
    int         n_err;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    // Walks the expected state trace; checks the state each cycle, alu_func in
    // EXEC_R, mem_we in MEM_WR, pc_src/pc_we in JUMP, and that reg_we is high
    // exactly in the write-back states.
    task automatic play(input string tag, input logic [1:0] alu_exp);
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, ".state"}, state_o, e);
            check_eq({tag, ".reg_we"}, reg_we,
                     (e == S_WB_R || e == S_WB_I || e == S_WB_MEM));
            if (e == S_EXEC_R) check_eq({tag, ".alu_func"}, alu_func, alu_exp);
            if (e == S_MEM_WR) check_eq({tag, ".mem_we"}, mem_we, 1);
            if (e == S_JUMP) begin
                check_eq({tag, ".pc_src"}, pc_src, 2'b10);
                check_eq({tag, ".pc_we"}, pc_we, 1);
            end
            cyc();
        end
    endtask

    logic [5:0] fn_tab  [3];
    logic [1:0] alu_tab [3];

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zf = 1'b0; mem_ready = 1'b1;
        repeat (2) cyc();

        // Reset state: FETCH defaults, no request, no strobes.
        check_eq("rst.state", state_o, S_FETCH);
        check_eq("rst.mem_req", mem_req, 0);
        check_eq("rst.ir_we", ir_we, 0);
        check_eq("rst.pc_we", pc_we, 0);
        check_eq("rst.alu_src_b", alu_src_b, 2'b01);
        check_eq("rst.alu_func", alu_func, 2'b11);
        check_eq("rst.reg_we", reg_we, 0);

        rst_n = 1'b1;
        #1;
        // add: FETCH, DECODE, EXEC_R, WB_R
        check_eq("add.f.mem_req", mem_req, 1);
        check_eq("add.f.ir_we", ir_we, 1);
        check_eq("add.f.pc_we", pc_we, 1);
        check_eq("add.f.iord", iord, 0);
        cyc();
        check_eq("add.d.state", state_o, S_DECODE);
        check_eq("add.d.alu_src_b", alu_src_b, 2'b11);
        check_eq("add.d.illegal", illegal, 0);
        cyc();
        check_eq("add.e.state", state_o, S_EXEC_R);
        check_eq("add.e.alu_func", alu_func, 2'b11);
        check_eq("add.e.alu_src_a", alu_src_a, 1);
        check_eq("add.e.alu_src_b", alu_src_b, 2'b00);
        cyc();
        check_eq("add.w.state", state_o, S_WB_R);
        check_eq("add.w.reg_we", reg_we, 1);
        check_eq("add.w.reg_dst", reg_dst, 1);
        check_eq("add.w.mem_to_reg", mem_to_reg, 0);
        cyc();
        check_eq("add.end.state", state_o, S_FETCH);
        check_eq("add.end.reg_we", reg_we, 0);

        // lw with three wait cycles in MEM_RD: 8 cycles in total.
        opcode = OP_LW;
        cyc();
        check_eq("lw.d.state", state_o, S_DECODE);
        cyc();
        check_eq("lw.a.state", state_o, S_ADDR);
        check_eq("lw.a.alu_src_b", alu_src_b, 2'b10);
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            check_eq("lw.m.state", state_o, S_MEM_RD);
            check_eq("lw.m.mem_req", mem_req, 1);
            check_eq("lw.m.iord", iord, 1);
            check_eq("lw.m.ir_we", ir_we, 0);
            cyc();
        end
        check_eq("lw.w.state", state_o, S_WB_MEM);
        check_eq("lw.w.reg_we", reg_we, 1);
        check_eq("lw.w.mem_to_reg", mem_to_reg, 1);
        check_eq("lw.w.reg_dst", reg_dst, 0);
        cyc();
        check_eq("lw.end.state", state_o, S_FETCH);

        // beq taken then not taken.
        for (int t = 1; t >= 0; t--) begin
            opcode = OP_BEQ;
            zf = t[0];
            cyc();
            check_eq("beq.d.state", state_o, S_DECODE);
            cyc();
            check_eq("beq.b.state", state_o, S_BRANCH);
            check_eq("beq.b.pc_we", pc_we, t[0]);
            check_eq("beq.b.pc_src", pc_src, 2'b01);
            check_eq("beq.b.alu_func", alu_func, 2'b10);
            cyc();
            check_eq("beq.end.state", state_o, S_FETCH);
        end
        zf = 1'b0;

        // Illegal opcode caught in DECODE.
        opcode = 6'h3F;
        cyc();
        check_eq("ill_op.d.illegal", illegal, 1);
        check_eq("ill_op.d.reg_we", reg_we, 0);
        check_eq("ill_op.d.mem_we", mem_we, 0);
        cyc();
        check_eq("ill_op.end.state", state_o, S_FETCH);
        check_eq("ill_op.end.illegal", illegal, 0);

        // Illegal R-type funct caught in EXEC_R.
        opcode = OP_RTYPE; funct = 6'h00;
        cyc();
        check_eq("ill_fn.d.illegal", illegal, 0);
        cyc();
        check_eq("ill_fn.e.state", state_o, S_EXEC_R);
        check_eq("ill_fn.e.illegal", illegal, 1);
        cyc();
        check_eq("ill_fn.end.state", state_o, S_FETCH);

        // slt / or / sub
        fn_tab  = '{6'h2A, 6'h25, 6'h22};
        alu_tab = '{2'b00, 2'b01, 2'b10};
        for (int k = 0; k < 3; k++) begin
            opcode = OP_RTYPE; funct = fn_tab[k];
            exp_q.push_back(S_FETCH);  exp_q.push_back(S_DECODE);
            exp_q.push_back(S_EXEC_R); exp_q.push_back(S_WB_R);
            play("rtype", alu_tab[k]);
        end

        // sw, addi, j
        opcode = OP_SW;
        exp_q.push_back(S_FETCH); exp_q.push_back(S_DECODE);
        exp_q.push_back(S_ADDR);  exp_q.push_back(S_MEM_WR);
        play("sw", 2'b00);
        opcode = OP_ADDI;
        exp_q.push_back(S_FETCH); exp_q.push_back(S_DECODE);
        exp_q.push_back(S_ADDR);  exp_q.push_back(S_WB_I);
        play("addi", 2'b00);
        opcode = OP_J;
        exp_q.push_back(S_FETCH); exp_q.push_back(S_DECODE);
        exp_q.push_back(S_JUMP);
        play("j", 2'b00);
        check_eq("j.end.state", state_o, S_FETCH);

        // Reset in the middle of a MEM_WR wait abandons the store.
        opcode = OP_SW;
        cyc();
        cyc();
        check_eq("swr.a.state", state_o, S_ADDR);
        mem_ready = 1'b0;
        cyc();
        check_eq("swr.m.mem_we", mem_we, 1);
        cyc();
        check_eq("swr.m2.state", state_o, S_MEM_WR);
        #2 rst_n = 1'b0;
        #1;
        check_eq("swr.rst.state", state_o, S_FETCH);
        check_eq("swr.rst.mem_req", mem_req, 0);
        check_eq("swr.rst.mem_we", mem_we, 0);
        cyc();
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        check_eq("swr.rel.mem_req", mem_req, 1);
        cyc();
        check_eq("swr.rel.state", state_o, S_DECODE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL: ports clk input 1, rising-edge clock; rst_n input 1, reset, asynchronous, active-low.
REQ-002 SHALL: opcode input 6 (instr[31:26]); funct input 6 (instr[5:0]); zf input 1 (ALU zero flag).
REQ-003 SHALL: mem_req output 1 (memory request); mem_we output 1 (write qualifier); mem_ready input 1 (memory completes the request this cycle).
REQ-004 SHALL: alu_func output 2, encoded 00 slt, 01 or, 10 sub, 11 add; alu_src_a output 1 (0 PC, 1 regA); alu_src_b output 2 (00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2).
REQ-005 SHALL: pc_we, ir_we, reg_we output 1 (write strobes); iord output 1 (0 PC address, 1 ALUOut address); reg_dst output 1 (0 rt, 1 rd); mem_to_reg output 1; pc_src output 2 (00 ALU result, 01 ALUOut, 10 jump target).
REQ-006 SHALL: illegal output 1 (one-cycle pulse on an unsupported instruction); state_o output 4 (current state, debug).

Function
REQ-007 SHALL: Moore FSM with states FETCH, DECODE, EXEC_R, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP; all outputs are 0 unless listed for the current state.
REQ-008 SHALL: FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_func=11; only when mem_ready=1: ir_we=1, pc_we=1, pc_src=00, next DECODE; else stay in FETCH.
REQ-009 SHALL: DECODE: alu_src_a=0, alu_src_b=11, alu_func=11 (branch target into ALUOut); next by opcode: 000000->EXEC_R, 100011/101011/001000->ADDR, 000100->BRANCH, 000010->JUMP, other->FETCH with illegal=1.
REQ-010 SHALL: EXEC_R: alu_src_a=1, alu_src_b=00; funct 100000->11, 100010->10, 100101->01, 101010->00, next WB_R; any other funct: illegal=1, next FETCH.
REQ-011 SHALL: ADDR: alu_src_a=1, alu_src_b=10, alu_func=11; next lw->MEM_RD, sw->MEM_WR, addi->WB_I.
REQ-012 SHALL: MEM_RD: mem_req=1, iord=1; hold until mem_ready=1, then next WB_MEM.
REQ-013 SHALL: MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready=1, then next FETCH.
REQ-014 SHALL: WB_R: reg_we=1, reg_dst=1, mem_to_reg=0; WB_I: reg_we=1, reg_dst=0, mem_to_reg=0; WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1; all next FETCH.
REQ-015 SHALL: BRANCH: alu_src_a=1, alu_src_b=00, alu_func=10; pc_we=zf, pc_src=01; next FETCH.
REQ-016 SHALL: JUMP: pc_we=1, pc_src=10; next FETCH.
REQ-017 SHALL: mem_req stays high and the request signals stay stable while waiting; mem_ready is ignored in every state other than FETCH, MEM_RD, MEM_WR.
REQ-018 SHALL: pc_we, ir_we, reg_we, mem_we and illegal are combinational from state plus mem_ready/zf/opcode/funct; no strobe lasts longer than one cycle per state visit, except that mem_req and mem_we remain high for the whole of a wait.
REQ-019 SHALL: cycle counts with zero wait: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2 or 3; each memory wait cycle adds 1.

Reset
REQ-020 SHALL: rst_n low forces the state to FETCH immediately; this includes a reset during a pending MEM_RD or MEM_WR wait, which abandons the request.
REQ-021 SHALL: during reset all outputs except the FETCH defaults are 0, with mem_req=0 while rst_n is low; the first fetch is requested on the first clock edge after reset release.

Structure
REQ-022 SHALL: shared package ctrl_pkg holds the state encoding, the opcode and funct constants, and the alu_func, alu_src_b and pc_src encodings; the ALU uses the same alu_func constants.
REQ-023 SHALL: single module with no submodules; the state register and the next-state/output logic sit in separate always blocks.

Verification
REQ-024 SHALL: reset release, mem_ready=1 constant, add (op 0, funct 0x20) -> states FETCH,DECODE,EXEC_R,WB_R; alu_func=11 in EXEC_R; reg_we=1 and reg_dst=1 for one cycle.
REQ-025 SHALL: lw with mem_ready low for 3 cycles in MEM_RD -> mem_req=1 and iord=1 for 4 cycles, then WB_MEM with mem_to_reg=1; total 8 cycles.
REQ-026 SHALL: beq with zf=1 -> pc_we=1 and pc_src=01 in BRANCH; with zf=0 -> pc_we=0; both return to FETCH after 3 cycles.
REQ-027 SHALL: opcode 0x3F -> illegal=1 in DECODE, no reg_we/mem_we, next FETCH; R-type funct 0x00 -> illegal=1 in EXEC_R.
REQ-028 SHALL: rst_n asserted mid-wait in MEM_WR -> state_o=FETCH immediately, mem_req=0 and mem_we=0 asynchronously; normal fetch after release.
REQ-029 SHALL: slt, or, sub, sw, addi, j each run once -> alu_func 00/01/10 in EXEC_R, sw ends without reg_we, j gives pc_src=10.
